// File: rtl/bmc_soft_pipe_if.sv
// Stream bundle between the depuncturer, the branch-metric unit and the ACS array.
// The master drives symbol groups and accepts metrics; the slave is the metric unit.
interface bmc_soft_pipe_if #(
   parameter int N      = 2,
   parameter int SOFT_W = 3
);
   localparam int BM_W = SOFT_W + $clog2(N);
   localparam int NH   = 32'd1 << N;

   logic                 in_valid;
   logic                 in_ready;
   logic [N*SOFT_W-1:0]  in_sym;
   logic [N-1:0]         in_erase;
   logic                 in_hard;
   logic                 out_valid;
   logic                 out_ready;
   logic [NH*BM_W-1:0]   out_bm;

   modport master (
      output in_valid, in_sym, in_erase, in_hard, out_ready,
      input  in_ready, out_valid, out_bm
   );

   modport slave (
      input  in_valid, in_sym, in_erase, in_hard, out_ready,
      output in_ready, out_valid, out_bm
   );
endinterface

// File: rtl/bmc_soft_pipe.sv
// Two-stage soft/hard branch-metric unit: S1 registers raw metrics for all 2^N
// hypotheses, S2 registers them optionally normalised by their minimum.
module bmc_soft_pipe #(
   parameter int N      = 2,
   parameter int SOFT_W = 3,
   parameter int NORM   = 1,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   bmc_soft_pipe_if.slave       bus,
   output logic [CNT_W-1:0]     sym_cnt
);
   localparam int BM_W = SOFT_W + $clog2(N);
   localparam int NH   = 32'd1 << N;
   localparam logic [SOFT_W-1:0] SMAX = {SOFT_W{1'b1}};

   // Cost of one code bit; erased bits contribute nothing in either mode.
   function automatic logic [BM_W-1:0] bit_cost(
      input logic [SOFT_W-1:0] s,
      input logic              e,
      input logic              hard,
      input logic              erased
   );
      logic [BM_W-1:0] cost_v;
      if (erased) begin
         cost_v = {BM_W{1'b0}};
      end else if (hard) begin
         cost_v = {{(BM_W-1){1'b0}}, s[SOFT_W-1] ^ e};
      end else if (e) begin
         cost_v = BM_W'(SMAX - s);
      end else begin
         cost_v = BM_W'(s);
      end
      return cost_v;
   endfunction

   // Sum of bit costs for hypothesis hyp; the N-way sum always fits BM_W bits.
   function automatic logic [BM_W-1:0] hyp_metric(
      input logic [N-1:0]          hyp,
      input logic [N*SOFT_W-1:0]   sym,
      input logic [N-1:0]          erase,
      input logic                  hard
   );
      logic [BM_W-1:0] sum_v;
      sum_v = {BM_W{1'b0}};
      for (int j = 0; j < N; j++) begin
         sum_v = sum_v + bit_cost(sym[j*SOFT_W +: SOFT_W], hyp[j], hard, erase[j]);
      end
      return sum_v;
   endfunction

   logic                 s1_valid_r;
   logic [NH*BM_W-1:0]   s1_bm_r;
   logic                 out_valid_r;
   logic [NH*BM_W-1:0]   out_bm_r;
   logic [CNT_W-1:0]     sym_cnt_r;

   logic                 en1_s;
   logic                 en2_s;
   logic                 accept_s;
   logic [NH*BM_W-1:0]   raw_bm_s;
   logic [BM_W-1:0]      min_s;
   logic [NH*BM_W-1:0]   norm_bm_s;

   // Handshake: a stage may load when it is empty or its contents move on this cycle.
   always_comb begin
      en2_s    = ~out_valid_r | bus.out_ready;
      en1_s    = ~s1_valid_r | en2_s;
      accept_s = bus.in_valid & en1_s & ~rst;
   end

   // Raw metrics for every hypothesis from the incoming group.
   always_comb begin
      raw_bm_s = {(NH*BM_W){1'b0}};
      for (int c = 0; c < NH; c++) begin
         raw_bm_s[c*BM_W +: BM_W] = hyp_metric(N'(c), bus.in_sym, bus.in_erase, bus.in_hard);
      end
   end

   // Minimum over the S1 metrics, used only when normalising.
   always_comb begin
      min_s = s1_bm_r[BM_W-1:0];
      for (int c = 1; c < NH; c++) begin
         min_s = (s1_bm_r[c*BM_W +: BM_W] < min_s) ? s1_bm_r[c*BM_W +: BM_W] : min_s;
      end
   end

   // S2 payload: min-subtracted or raw metrics.
   always_comb begin
      norm_bm_s = {(NH*BM_W){1'b0}};
      for (int c = 0; c < NH; c++) begin
         if (NORM != 0) begin
            norm_bm_s[c*BM_W +: BM_W] = s1_bm_r[c*BM_W +: BM_W] - min_s;
         end else begin
            norm_bm_s[c*BM_W +: BM_W] = s1_bm_r[c*BM_W +: BM_W];
         end
      end
   end

   // Pipeline stages and accepted-group counter; data registers load only with valid data.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_bm_r     <= {(NH*BM_W){1'b0}};
         out_valid_r <= 1'b0;
         out_bm_r    <= {(NH*BM_W){1'b0}};
         sym_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         if (en1_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
               s1_bm_r <= raw_bm_s;
            end
         end
         if (en2_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
               out_bm_r <= norm_bm_s;
            end
         end
         if (accept_s) begin
            sym_cnt_r <= sym_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // in_ready is forced high while reset is asserted; acceptance is still blocked by rst.
   assign bus.in_ready  = rst | en1_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_bm    = out_bm_r;
   assign sym_cnt       = sym_cnt_r;
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Scoreboard bench: a raw (NORM=0, CNT_W=16) and a normalising (NORM=1, CNT_W=4)
// unit receive identical groups; monitors pop expected metrics on each output transfer.
module tb_bmc_soft_pipe;
   localparam int N = 2;
   localparam int SOFT_W = 3;

   typedef struct packed {
      logic [2:0]  r1;
      logic [2:0]  r0;
      logic [1:0]  er;
      logic        hard;
      logic [15:0] raw;   // {c3,c2,c1,c0} nibbles
      logic [15:0] nrm;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] cnt_raw;
   logic [3:0]  cnt_nrm;
   int n_checks = 0;
   int n_pass = 0;
   vec_t vecs[10];
   logic [15:0] q_raw[$];
   logic [15:0] q_nrm[$];

   always #5 clk = ~clk;

   bmc_soft_pipe_if #(.N(N), .SOFT_W(SOFT_W)) ifr ();
   bmc_soft_pipe_if #(.N(N), .SOFT_W(SOFT_W)) ifn ();

   bmc_soft_pipe #(.N(N), .SOFT_W(SOFT_W), .NORM(0), .CNT_W(16)) u_raw (
      .clk(clk), .rst(rst), .bus(ifr.slave), .sym_cnt(cnt_raw));
   bmc_soft_pipe #(.N(N), .SOFT_W(SOFT_W), .NORM(1), .CNT_W(4)) u_nrm (
      .clk(clk), .rst(rst), .bus(ifn.slave), .sym_cnt(cnt_nrm));

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
   endfunction

   task automatic send(input vec_t v);
      bit acc_r = 1'b0;
      bit acc_n = 1'b0;
      int t = 0;
      ifr.in_sym = {v.r1, v.r0}; ifr.in_erase = v.er; ifr.in_hard = v.hard; ifr.in_valid = 1'b1;
      ifn.in_sym = {v.r1, v.r0}; ifn.in_erase = v.er; ifn.in_hard = v.hard; ifn.in_valid = 1'b1;
      while (!(acc_r && acc_n) && t < 50) begin
         @(negedge clk);
         if (!acc_r && ifr.in_ready) begin q_raw.push_back(v.raw); acc_r = 1'b1; end
         if (!acc_n && ifn.in_ready) begin q_nrm.push_back(v.nrm); acc_n = 1'b1; end
         @(posedge clk); #1;
         if (acc_r) ifr.in_valid = 1'b0;
         if (acc_n) ifn.in_valid = 1'b0;
         t++;
      end
      if (!(acc_r && acc_n)) chk("send_timeout", {30'd0, acc_r, acc_n}, 32'd3);
      ifr.in_valid = 1'b0;
      ifn.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q_raw.size() != 0 || q_nrm.size() != 0) && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("drain_raw_q", q_raw.size(), 32'd0);
      chk("drain_nrm_q", q_nrm.size(), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q_raw.delete();
      q_nrm.delete();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Output monitors: compare on every transfer and require stable data while stalled.
   initial begin
      logic hold_r, hold_n;
      logic [15:0] hold_r_bm, hold_n_bm;
      hold_r = 1'b0; hold_n = 1'b0; hold_r_bm = 16'h0; hold_n_bm = 16'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_r = 1'b0;
            hold_n = 1'b0;
         end else begin
            if (hold_r) begin
               chk("raw_hold_valid", ifr.out_valid, 32'd1);
               chk("raw_hold_bm", ifr.out_bm, hold_r_bm);
            end
            if (hold_n) begin
               chk("nrm_hold_valid", ifn.out_valid, 32'd1);
               chk("nrm_hold_bm", ifn.out_bm, hold_n_bm);
            end
            if (ifr.out_valid && ifr.out_ready) begin
               if (q_raw.size() == 0) chk("raw_unexpected_out", ifr.out_valid, 32'd0);
               else chk("raw_bm", ifr.out_bm, q_raw.pop_front());
            end
            if (ifn.out_valid && ifn.out_ready) begin
               if (q_nrm.size() == 0) chk("nrm_unexpected_out", ifn.out_valid, 32'd0);
               else chk("nrm_bm", ifn.out_bm, q_nrm.pop_front());
            end
            hold_r = ifr.out_valid && !ifr.out_ready;
            hold_n = ifn.out_valid && !ifn.out_ready;
            hold_r_bm = ifr.out_bm;
            hold_n_bm = ifn.out_bm;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //           r1    r0    erase  hard  raw       norm
      vecs[0] = '{3'd7, 3'd0, 2'b00, 1'b0, 16'h70E7, 16'h70E7};
      vecs[1] = '{3'd4, 3'd3, 2'b00, 1'b0, 16'h7687, 16'h1021};
      vecs[2] = '{3'd4, 3'd3, 2'b00, 1'b1, 16'h1021, 16'h1021};
      vecs[3] = '{3'd4, 3'd3, 2'b10, 1'b0, 16'h4343, 16'h1010};
      vecs[4] = '{3'd4, 3'd3, 2'b11, 1'b0, 16'h0000, 16'h0000};
      vecs[5] = '{3'd1, 3'd2, 2'b00, 1'b0, 16'hB863, 16'h8530};
      vecs[6] = '{3'd6, 3'd5, 2'b00, 1'b0, 16'h368B, 16'h0358};
      vecs[7] = '{3'd3, 3'd3, 2'b00, 1'b1, 16'h2110, 16'h2110};
      vecs[8] = '{3'd0, 3'd7, 2'b01, 1'b0, 16'h7700, 16'h7700};
      vecs[9] = '{3'd5, 3'd1, 2'b00, 1'b0, 16'h83B6, 16'h5083};

      rst = 1'b1;
      ifr.in_valid = 1'b0; ifr.in_sym = 6'd0; ifr.in_erase = 2'b00; ifr.in_hard = 1'b0; ifr.out_ready = 1'b1;
      ifn.in_valid = 1'b0; ifn.in_sym = 6'd0; ifn.in_erase = 2'b00; ifn.in_hard = 1'b0; ifn.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", ifr.out_valid, 32'd0);
      chk("rst_out_bm", ifr.out_bm, 32'd0);
      chk("rst_sym_cnt", cnt_raw, 32'd0);
      chk("rst_in_ready", ifn.in_ready, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed metrics, with a latency check on the first group.
      send(vecs[0]);
      @(negedge clk);
      chk("lat_1cyc_raw", ifr.out_valid, 32'd0);
      chk("lat_1cyc_nrm", ifn.out_valid, 32'd0);
      @(negedge clk);
      chk("lat_2cyc_raw", ifr.out_valid, 32'd1);
      chk("lat_2cyc_nrm", ifn.out_valid, 32'd1);
      @(posedge clk); #1;
      for (int i = 1; i < 5; i++) send(vecs[i]);
      drain();
      chk("cnt_after_directed_raw", cnt_raw, 32'd5);
      chk("cnt_after_directed_nrm", cnt_nrm, 32'd5);

      // Back-to-back stream with a three-cycle downstream stall.
      do_reset();
      fork
         begin
            for (int i = 5; i < 10; i++) send(vecs[i]);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            ifr.out_ready = 1'b0;
            ifn.out_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("stall_in_ready_raw", ifr.in_ready, 32'd0);
            chk("stall_in_ready_nrm", ifn.in_ready, 32'd0);
            chk("stall_out_valid", ifr.out_valid, 32'd1);
            @(posedge clk); #1;
            ifr.out_ready = 1'b1;
            ifn.out_ready = 1'b1;
         end
      join
      drain();
      chk("cnt_after_stream_raw", cnt_raw, 32'd5);
      chk("cnt_after_stream_nrm", cnt_nrm, 32'd5);

      // Counter wrap: 17 groups through a 4-bit counter.
      do_reset();
      for (int i = 0; i < 17; i++) send(vecs[i % 10]);
      drain();
      chk("cnt17_raw", cnt_raw, 32'd17);
      chk("cnt17_wrap_nrm", cnt_nrm, 32'd1);

      // Reset with two groups in flight.
      ifr.out_ready = 1'b0;
      ifn.out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[3]);
      rst = 1'b1;
      q_raw.delete();
      q_nrm.delete();
      @(negedge clk);
      chk("in_ready_during_rst", ifn.in_ready, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      ifr.out_ready = 1'b1;
      ifn.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", ifn.out_valid, 32'd0);
      chk("flush_out_bm", ifn.out_bm, 32'd0);
      chk("flush_sym_cnt_raw", cnt_raw, 32'd0);
      chk("flush_sym_cnt_nrm", cnt_nrm, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_raw", ifr.out_valid, 32'd0);
         chk("no_stale_nrm", ifn.out_valid, 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bmc_soft_pipe.md
Name: bmc_soft_pipe

Overview:
- Parametrised, pipelined branch-metric unit for the Viterbi decoder. Replaces the per-codeword hard-decision BMC cells.
- Each accepted rate-1/N symbol group produces metrics for all 2^N codeword hypotheses in one beat.
- Supports soft or hard decisions, per-bit erasures for punctured codes, and optional min-normalisation.
- Sits between the depuncturer and the ACS array; valid/ready on both sides.

Parameters:
- N, 2, code outputs per trellis step (rate 1/N); legal range 2..4.
- SOFT_W, 3, soft sample width in bits; offset-binary, 0 = strong '0', 2^SOFT_W-1 = strong '1'.
- NORM, 1, 1 = subtract the minimum metric from all metrics; 0 = raw metrics.
- CNT_W, 16, width of the accepted-symbol counter.
- Derived, not overridable: BM_W = SOFT_W + clog2(N); NH = 2^N.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  symbol group valid.
- in_ready  out  1  unit can accept this cycle.
- in_sym  in  N*SOFT_W  sample j at [j*SOFT_W +: SOFT_W].
- in_erase  in  N  bit j = 1 marks sample j punctured.
- in_hard  in  1  1 = hard-decision metric for this group; travels with the data.
- out_valid  out  1  metrics valid.
- out_ready  in  1  downstream accepts.
- out_bm  out  NH*BM_W  metric for hypothesis c at [c*BM_W +: BM_W].
- sym_cnt  out  CNT_W  count of accepted groups; wraps.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_bm=0, sym_cnt=0, both pipeline valid flags cleared. Reset mid-operation discards in-flight data.
- in_ready is 1 during reset cycles, but no transfer occurs while rst=1.
- Hypothesis encoding: bit j of index c is the expected value of code bit j.
- Per-bit cost for sample s and expected bit e:
  - Soft mode: s if e=0; (2^SOFT_W-1)-s if e=1.
  - Hard mode: decision = MSB of s; cost = decision XOR e (0 or 1).
  - Erased bit: cost 0 in both modes.
- Raw metric = sum of the N bit costs. Unsigned; it fits in BM_W bits and cannot overflow.
- Pipeline, 2 stages:
  - S1 registers the raw metrics.
  - S2 registers the final metrics. With NORM=1, S2 computes the minimum over all NH raw metrics and subtracts it from each. With NORM=0, S2 passes raw metrics through.
  - Latency: 2 cycles from the in_valid & in_ready edge to out_valid, when there is no stall.
- Handshake:
  - en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1. All combinational from registered state plus out_ready; no combinational in_valid -> in_ready path.
  - Full throughput: one group per cycle while out_ready=1.
  - On stall, out_bm and out_valid hold stable until out_ready=1. Nothing is dropped or duplicated.
  - At most 2 groups in flight; in_ready falls only when both stages are full and out_ready=0.
- sym_cnt increments by 1 on each in_valid & in_ready cycle and wraps from 2^CNT_W-1 to 0.
- in_hard and in_erase are sampled with in_sym. A mode change between consecutive groups takes effect per group with no bubble.
- All-erased group: every metric is 0.
- out_bm is don't-care-free: it holds its last value when out_valid=0.

Test Plan:
- N=2, SOFT_W=3, NORM=0, soft, in_sym={r1=7, r0=0}, no erase -> out_bm[c=0..3] = 7, 14, 0, 7. out_valid two cycles after acceptance.
- Same config, NORM=1, in_sym={r1=4, r0=3} -> raw 7, 8, 6, 7 -> out_bm = 1, 2, 0, 1.
- Hard mode, in_sym={r1=4, r0=3} -> decisions bit1=1, bit0=0 -> out_bm = 1, 2, 0, 1 (Hamming distances).
- NORM=1, soft, in_sym={4,3}, in_erase=2'b10 -> raw 3, 4, 3, 4 -> out_bm = 0, 1, 0, 1. With in_erase=2'b11 -> all 0.
- Backpressure: stream 5 distinct groups back to back, hold out_ready=0 for 3 cycles mid-stream. Required: in_ready drops once 2 groups are buffered, output order and values match the model, sym_cnt=5, no loss or duplication.
- CNT_W=4: accept 17 groups -> sym_cnt=1. Assert rst with 2 groups in flight -> next cycle out_valid=0, sym_cnt=0, and no stale output after reset.
